// File: rtl/fwft_fifo_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFOs.
package fwft_fifo_pkg;

  localparam int unsigned AlmostEmptyDefault = 1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned result;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwft_sync_fifo_mem.sv
// Depth x width storage array: synchronous write port, asynchronous read port.
module fwft_sync_fifo_mem #(
  parameter int unsigned width  = 32,
  parameter int unsigned addr_w = 1,
  parameter int unsigned depth  = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [addr_w-1:0] waddr_i,
  input  logic [width-1:0]  wdata_i,
  input  logic [addr_w-1:0] raddr_i,
  output logic [width-1:0]  rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fwft_sync_fifo.sv
// Single-clock show-ahead FIFO; the head word sits on read_data whenever not empty.
// Define FWFT_SYNC_FIFO_ALMOST_FLAGS_EN to build the almost_empty/almost_full comparators.
module fwft_sync_fifo
  import fwft_fifo_pkg::*;
#(
  parameter int unsigned width              = 32,
  parameter int unsigned widthad            = 1,
  parameter int unsigned depth              = 2,
  parameter int unsigned almost_empty_value = AlmostEmptyDefault,
  parameter int unsigned almost_full_value  = depth - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  output logic               full,
  input  logic               write_en,
  input  logic [width-1:0]   write_data,
  output logic               empty,
  input  logic               read_en,
  output logic [width-1:0]   read_data,
  output logic [widthad:0]   usedw,
  output logic               almost_empty,
  output logic               almost_full
);

  localparam logic [widthad-1:0] LastPtr  = widthad'(depth - 1);
  localparam logic [widthad:0]   DepthCnt = (widthad + 1)'(depth);

  logic [widthad-1:0] wr_ptr_q, wr_ptr_d;
  logic [widthad-1:0] rd_ptr_q, rd_ptr_d;
  logic [widthad:0]   usedw_q, usedw_d;
  logic               wr_accept, rd_accept;
  logic               empty_int, full_int;
  logic [width-1:0]   mem_rdata;

  always_comb begin
    empty_int = (usedw_q == '0);
    full_int  = (usedw_q == DepthCnt);
    // full is judged on the pre-pop occupancy, so write+read while full drops the write.
    wr_accept = clken & write_en & ~full_int;
    rd_accept = clken & read_en & ~empty_int;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_accept, rd_accept})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  fwft_sync_fifo_mem #(
    .width  (width),
    .addr_w (widthad),
    .depth  (depth)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign read_data = empty_int ? '0 : mem_rdata;
  assign empty     = empty_int;
  assign full      = full_int;
  assign usedw     = usedw_q;

`ifdef FWFT_SYNC_FIFO_ALMOST_FLAGS_EN
  localparam logic [widthad:0] AlmostEmptyCnt = (widthad + 1)'(almost_empty_value);
  localparam logic [widthad:0] AlmostFullCnt  = (widthad + 1)'(almost_full_value);

  assign almost_empty = (usedw_q <= AlmostEmptyCnt);
  assign almost_full  = (usedw_q >= AlmostFullCnt);
`else
  assign almost_empty = 1'b0;
  assign almost_full  = 1'b0;
`endif

  param_ok_a: assert property (@(posedge clk)
    (depth >= 2) && (widthad >= clog2(depth)) &&
    (almost_empty_value <= depth) && (almost_full_value <= depth));

  usedw_bound_a: assert property (@(posedge clk) disable iff (reset) usedw_q <= DepthCnt);

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Scoreboard bench for fwft_sync_fifo: queue reference model plus a negedge monitor.
module tb_fwft_sync_fifo;

  localparam int unsigned Width   = 8;
  localparam int unsigned Widthad = 2;
  localparam int unsigned Depth   = 3;
  localparam int unsigned AeVal   = 1;
  localparam int unsigned AfVal   = Depth - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clken = 1'b0;
  logic               write_en = 1'b0;
  logic               read_en = 1'b0;
  logic [Width-1:0]   write_data = '0;
  logic               full, empty, almost_empty, almost_full;
  logic [Width-1:0]   read_data;
  logic [Widthad:0]   usedw;

  int n_checks = 0;
  int n_errors = 0;

  logic [Width-1:0] model_q[$];
  bit               acc_w, acc_r;

  fwft_sync_fifo #(
    .width              (Width),
    .widthad            (Widthad),
    .depth              (Depth),
    .almost_empty_value (AeVal),
    .almost_full_value  (AfVal)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .full         (full),
    .write_en     (write_en),
    .write_data   (write_data),
    .empty        (empty),
    .read_en      (read_en),
    .read_data    (read_data),
    .usedw        (usedw),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue with a capacity of Depth.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (clken) begin
      acc_w = write_en && (model_q.size() < Depth);
      acc_r = read_en && (model_q.size() > 0);
      if (acc_r) void'(model_q.pop_front());
      if (acc_w) model_q.push_back(write_data);
    end
  end

  // Monitor: compare every observable output against the model away from the edge.
  always @(negedge clk) begin
    int unsigned n;
    logic [Width-1:0] head;
    n    = model_q.size();
    head = (n > 0) ? model_q[0] : '0;
    chk("usedw", 32'(usedw), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == Depth));
    chk("read_data", 32'(read_data), 32'(head));
`ifdef FWFT_SYNC_FIFO_ALMOST_FLAGS_EN
    chk("almost_empty", 32'(almost_empty), 32'(n <= AeVal));
    chk("almost_full", 32'(almost_full), 32'(n >= AfVal));
`else
    chk("almost_empty", 32'(almost_empty), 32'd0);
    chk("almost_full", 32'(almost_full), 32'd0);
`endif
  end

  task automatic drive(input bit ce, input bit we, input bit re, input logic [Width-1:0] d);
    @(posedge clk);
    #2;
    clken      = ce;
    write_en   = we;
    read_en    = re;
    write_data = d;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // Fill, overfill, write+read while full, drain, read on empty.
    drive(1, 1, 0, 8'h0A);
    drive(1, 1, 0, 8'h0B);
    drive(1, 1, 0, 8'h0C);
    drive(1, 1, 0, 8'h0D);
    drive(1, 1, 1, 8'h0E);
    drive(1, 0, 1, 8'h00);
    drive(1, 0, 1, 8'h00);
    drive(1, 0, 1, 8'h00);
    drive(1, 0, 0, 8'h00);
    // Simultaneous push/pop at occupancy 1.
    drive(1, 1, 0, 8'h05);
    drive(1, 1, 1, 8'h06);
    drive(1, 0, 0, 8'h00);
    // Clock enable low freezes everything.
    drive(1, 1, 0, 8'h07);
    drive(0, 1, 1, 8'h08);
    drive(0, 1, 1, 8'h09);
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 1, 8'h00);

    // Alternating push-heavy / pop-heavy bursts across pointer wrap.
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 25; i++) begin
        if (b % 2 == 0)
          drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, Width'($urandom));
        else
          drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0, Width'($urandom));
      end
    end

    // Drain, load two words, then assert reset between edges.
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 8'h00);
    drive(1, 1, 0, 8'h31);
    drive(1, 1, 0, 8'h32);
    drive(1, 0, 0, 8'h00);
    #1 chk("pre_reset_usedw", 32'(usedw), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_usedw", 32'(usedw), 32'd0);
    chk("async_reset_empty", 32'(empty), 32'd1);
    chk("async_reset_read_data", 32'(read_data), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    drive(1, 1, 0, 8'h44);
    drive(1, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
